sdram_word_adapter: RTL and testbench
=====================================

Name: sdram_word_adapter

Overview:
- Sits directly upstream of the byte-wide SDRAM controller. It turns one core-side byte, halfword or word access into 1, 2 or 4 sequential byte transactions on the controller's request/done handshake.
- Assembles little-endian read data, pulses a single completion to the core, and guards each byte transaction with a timeout.
- Guarantees at most one outstanding request to the controller, because the controller records only one pending request.

Parameters:
- ADDR_W, 23, byte address width (matches controller address).
- TIMEOUT, 4096, max cycles to wait for i_sd_done per byte before aborting.

Ports:
- i_clk  in  1  system clock; also clocks the controller.
- i_rst_n  in  1  reset; one clock, asynchronous, active-low.
- i_request  in  1  core request strobe, sampled only while o_busy=0.
- i_wren  in  1  1=write, 0=read; sampled with i_request.
- i_size  in  2  00=byte, 01=halfword, 10=word, 11=illegal.
- i_address  in  ADDR_W  byte address of lowest byte; no alignment required.
- i_wdata  in  32  write data, little-endian; byte k goes to address+k.
- o_rdata  out  32  read data, zero-extended; valid in the o_done cycle and held until the next accepted request.
- o_done  out  1  one-cycle pulse when the access completes or aborts.
- o_error  out  1  asserted with o_done on timeout or illegal size.
- o_busy  out  1  high from the cycle after acceptance until the o_done cycle, inclusive.
- o_sd_request  out  1  one-cycle request pulse to the controller.
- o_sd_wren  out  1  controller write enable, stable from pulse to i_sd_done.
- o_sd_address  out  ADDR_W  controller byte address.
- o_sd_data  out  8  controller write byte.
- i_sd_data  in  8  controller read byte, valid when i_sd_done=1.
- i_sd_done  in  1  controller completion pulse.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE.
  - All outputs 0: o_rdata, o_done, o_error, o_busy, o_sd_request, o_sd_wren, o_sd_address, o_sd_data.
  - Byte counter and timeout counter 0.
- Reset mid-access drops the access without any o_done. The controller may still finish its byte; an i_sd_done seen in IDLE is ignored.
- States: IDLE, ISSUE, WAIT, FINISH.
- IDLE:
  - On i_request=1, latch i_wren, i_size, i_address, i_wdata.
  - Set nbytes = 1/2/4 for size 00/01/10, clear o_rdata, go to ISSUE.
  - For i_size=11: go to FINISH with error set; no controller traffic.
- ISSUE (1 cycle):
  - o_sd_request=1.
  - o_sd_address = (addr_latched + k) mod 2^ADDR_W, where k = byte index 0..nbytes-1.
  - o_sd_data = wdata[8k+7:8k]; o_sd_wren = latched wren.
  - Clear timeout counter; go to WAIT.
- WAIT:
  - o_sd_request=0; address, data and wren held.
  - On i_sd_done: for a read, o_rdata[8k+7:8k] <= i_sd_data. Then k+1 < nbytes → increment k, go to ISSUE. Otherwise go to FINISH.
  - Timeout counter increments each WAIT cycle. Reaching TIMEOUT-1 without i_sd_done → go to FINISH with error set; remaining bytes are not issued.
  - If i_sd_done and timeout occur in the same cycle, done wins (no error).
- FINISH (1 cycle):
  - o_done=1 and o_error=error; o_busy is still 1 in this cycle.
  - Next state IDLE.
  - o_rdata on error holds the bytes received so far; the other bytes are 0.
- i_request while o_busy=1 is ignored, with no queuing. A request can be accepted in the cycle after FINISH.
- Latency: 2 + sum over bytes of (1 ISSUE + WAIT cycles up to and including i_sd_done) cycles from the i_request edge to o_done.
- Address wrap: 0x7FFFFF + 1 → 0x000000 with no error.

Decomposition:
- Shared package sdram_pkg:
  - state encodings IDLE/ISSUE/WAIT/FINISH;
  - size codes SZ_BYTE/SZ_HALF/SZ_WORD;
  - ADDR_W default.
- Sub-module sdram_txn_timer (load/enable/expired counter, TIMEOUT param) is natural. Everything else stays in one module.

Test Plan:
- Word write: addr=0x000100, wdata=0xDEADBEEF, controller model done 8 cycles after request → four requests at 0x100..0x103 with data EF,BE,AD,DE. One o_done, o_error=0, latency 2+4×9=38.
- Halfword read: addr=0x7FFFFF, model returns 0x34 then 0x12 → addresses 0x7FFFFF then 0x000000, o_rdata=0x00001234.
- Byte read: addr=0x000010, returns 0xA5 → one request, o_rdata=0x000000A5, o_done once.
- Busy/back-to-back:
  - Assert i_request every cycle during a word read → only the first is accepted.
  - A second request is accepted in the cycle after o_done.
- Timeout: TIMEOUT=16, model never sends done on byte 1 of a word read → o_done=o_error=1 16 cycles after the second request, o_rdata holds byte 0 only, no further requests.
- Illegal size, then reset:
  - i_size=11 → o_done=o_error=1 two cycles later, zero controller requests.
  - Reset asserted mid-WAIT → all outputs 0 immediately, no o_done after release.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared encodings for the byte-wide SDRAM front end: FSM states,
// core access size codes and the default controller address width.
package sdram_pkg;

    localparam int SDRAM_ADDR_W = 23;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        FINISH = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } size_t;

    function automatic logic [2:0] size_to_nbytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/sdram_txn_timer.sv
// Per-byte watchdog: cleared while a byte is issued, counts wait cycles and
// flags the wait cycle in which the count reaches TIMEOUT-1.
module sdram_txn_timer #(
    parameter int TIMEOUT = 4096
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic load,
    input  logic enable,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;

    assign count_nxt = count + CNT_W'(1);
    assign expired   = enable && (count_nxt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (enable) begin
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/sdram_word_adapter.sv
// Splits one core byte/halfword/word access into sequential byte transactions
// on the single-outstanding SDRAM controller handshake, little-endian.
module sdram_word_adapter
    import sdram_pkg::*;
#(
    parameter int ADDR_W  = SDRAM_ADDR_W,
    parameter int TIMEOUT = 4096
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_request,
    input  logic              i_wren,
    input  logic [1:0]        i_size,
    input  logic [ADDR_W-1:0] i_address,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata,
    output logic              o_done,
    output logic              o_error,
    output logic              o_busy,
    output logic              o_sd_request,
    output logic              o_sd_wren,
    output logic [ADDR_W-1:0] o_sd_address,
    output logic [7:0]        o_sd_data,
    input  logic [7:0]        i_sd_data,
    input  logic              i_sd_done
);
    state_t            state;
    logic              wren_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [2:0]        nbytes_q;
    logic [1:0]        idx_q;
    logic [1:0]        idx_nxt;
    logic              last_byte;
    logic              timer_expired;

    assign idx_nxt   = idx_q + 2'd1;
    assign last_byte = ({1'b0, idx_q} + 3'd1) == nbytes_q;

    sdram_txn_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .load   (state == ISSUE),
        .enable (state == WAIT),
        .expired(timer_expired)
    );

    // Outputs are registered on the transition into the state that owns them,
    // so o_sd_request coincides with ISSUE and o_done with FINISH.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            wren_q       <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            nbytes_q     <= '0;
            idx_q        <= '0;
            o_rdata      <= '0;
            o_done       <= 1'b0;
            o_error      <= 1'b0;
            o_busy       <= 1'b0;
            o_sd_request <= 1'b0;
            o_sd_wren    <= 1'b0;
            o_sd_address <= '0;
            o_sd_data    <= '0;
        end else begin
            o_sd_request <= 1'b0;
            o_done       <= 1'b0;
            o_error      <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_request) begin
                        wren_q   <= i_wren;
                        addr_q   <= i_address;
                        wdata_q  <= i_wdata;
                        nbytes_q <= size_to_nbytes(i_size);
                        idx_q    <= '0;
                        o_rdata  <= '0;
                        o_busy   <= 1'b1;
                        if (i_size == SZ_BAD) begin
                            state   <= FINISH;
                            o_done  <= 1'b1;
                            o_error <= 1'b1;
                        end else begin
                            state        <= ISSUE;
                            o_sd_request <= 1'b1;
                            o_sd_wren    <= i_wren;
                            o_sd_address <= i_address;
                            o_sd_data    <= i_wdata[7:0];
                        end
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    // A completion in the expiry cycle still counts as success.
                    if (i_sd_done) begin
                        if (!wren_q) begin
                            o_rdata[{idx_q, 3'b000} +: 8] <= i_sd_data;
                        end
                        if (last_byte) begin
                            state  <= FINISH;
                            o_done <= 1'b1;
                        end else begin
                            state        <= ISSUE;
                            idx_q        <= idx_nxt;
                            o_sd_request <= 1'b1;
                            o_sd_address <= addr_q + ADDR_W'(idx_nxt);
                            o_sd_data    <= wdata_q[{idx_nxt, 3'b000} +: 8];
                        end
                    end else if (timer_expired) begin
                        state   <= FINISH;
                        o_done  <= 1'b1;
                        o_error <= 1'b1;
                    end
                end
                FINISH: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_word_adapter.sv
// Bench for sdram_word_adapter: byte-wide controller model with configurable
// response delay and dropped bytes, plus an access-level reference model.
module tb_sdram_word_adapter;
    localparam int ADDR_W  = 23;
    localparam int TIMEOUT = 16;

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b0;
    logic              i_request = 1'b0;
    logic              i_wren = 1'b0;
    logic [1:0]        i_size = 2'b00;
    logic [ADDR_W-1:0] i_address = '0;
    logic [31:0]       i_wdata = '0;
    logic [31:0]       o_rdata;
    logic              o_done;
    logic              o_error;
    logic              o_busy;
    logic              o_sd_request;
    logic              o_sd_wren;
    logic [ADDR_W-1:0] o_sd_address;
    logic [7:0]        o_sd_data;
    logic [7:0]        i_sd_data = 8'h00;
    logic              i_sd_done = 1'b0;

    int checks = 0;
    int errors = 0;

    sdram_word_adapter #(
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_request   (i_request),
        .i_wren      (i_wren),
        .i_size      (i_size),
        .i_address   (i_address),
        .i_wdata     (i_wdata),
        .o_rdata     (o_rdata),
        .o_done      (o_done),
        .o_error     (o_error),
        .o_busy      (o_busy),
        .o_sd_request(o_sd_request),
        .o_sd_wren   (o_sd_wren),
        .o_sd_address(o_sd_address),
        .o_sd_data   (o_sd_data),
        .i_sd_data   (i_sd_data),
        .i_sd_done   (i_sd_done)
    );

    always #5 i_clk = ~i_clk;

    // Controller model: answers each request rsp_delay cycles after the request
    // cycle, except the request whose index in the log equals drop_idx.
    int                rsp_delay = 8;
    int                drop_idx = -1;
    logic [7:0]        rsp_q[$];
    logic [ADDR_W-1:0] log_addr[$];
    logic [7:0]        log_data[$];
    logic              log_wren[$];
    int                done_cnt = 0;
    bit                pend = 1'b0;
    int                rem = 0;

    always @(negedge i_clk) begin
        i_sd_done = 1'b0;
        if (pend) begin
            rem = rem - 1;
            if (rem == 0) begin
                pend = 1'b0;
                i_sd_done = 1'b1;
                if (rsp_q.size() > 0) i_sd_data = rsp_q.pop_front();
                else i_sd_data = 8'h00;
            end
        end
        if (o_done) done_cnt = done_cnt + 1;
        if (o_sd_request) begin
            log_addr.push_back(o_sd_address);
            log_data.push_back(o_sd_data);
            log_wren.push_back(o_sd_wren);
            if (log_addr.size() - 1 != drop_idx) begin
                pend = 1'b1;
                rem  = rsp_delay;
            end
        end
    end

    int          obs_lat;
    logic        obs_err;
    logic [31:0] obs_rdata;
    int          obs_ndone;

    // Latency counts from the edge that accepts i_request to the edge that
    // samples o_done.
    task automatic run_access(input logic wren, input logic [1:0] size,
                              input logic [ADDR_W-1:0] addr, input logic [31:0] wdata);
        int cnt;
        int d0;
        bit seen;
        log_addr.delete();
        log_data.delete();
        log_wren.delete();
        @(negedge i_clk);
        d0 = done_cnt;
        i_request = 1'b1;
        i_wren    = wren;
        i_size    = size;
        i_address = addr;
        i_wdata   = wdata;
        @(posedge i_clk);
        cnt = 1;
        seen = 1'b0;
        obs_lat = -1;
        obs_err = 1'bx;
        obs_rdata = 'x;
        while (!seen && cnt < 400) begin
            @(negedge i_clk);
            i_request = 1'b0;
            if (o_done) begin
                seen      = 1'b1;
                obs_lat   = cnt + 1;
                obs_err   = o_error;
                obs_rdata = o_rdata;
            end else begin
                @(posedge i_clk);
                cnt++;
            end
        end
        repeat (4) @(negedge i_clk);
        #1;
        obs_ndone = done_cnt - d0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        checks++;
        if ({o_rdata, o_done, o_error, o_busy, o_sd_request, o_sd_wren, o_sd_address, o_sd_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rdata=%h done=%b err=%b busy=%b sreq=%b swren=%b saddr=%h sdata=%h, required all zero",
                     o_rdata, o_done, o_error, o_busy, o_sd_request, o_sd_wren, o_sd_address, o_sd_data);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic test_word_write();
        logic [31:0] wd;
        wd = 32'hDEADBEEF;
        rsp_delay = 8;
        drop_idx = -1;
        rsp_q.delete();
        run_access(1'b1, 2'b10, 23'h000100, wd);
        checks++;
        if (obs_lat !== 38) begin errors++; $display("FAIL word_write_latency: got %0d required 38", obs_lat); end
        checks++;
        if (obs_err !== 1'b0) begin errors++; $display("FAIL word_write_error: got %b required 0", obs_err); end
        checks++;
        if (obs_ndone !== 1) begin errors++; $display("FAIL word_write_done_count: got %0d required 1", obs_ndone); end
        checks++;
        if (log_addr.size() !== 4) begin errors++; $display("FAIL word_write_req_count: got %0d required 4", log_addr.size()); end
        for (int k = 0; k < 4 && k < log_addr.size(); k++) begin
            checks++;
            if (log_addr[k] !== ADDR_W'(32'h100 + k) || log_data[k] !== 8'(wd >> (8 * k)) || log_wren[k] !== 1'b1) begin
                errors++;
                $display("FAIL word_write_byte%0d: addr=%h data=%h wren=%b required addr=%h data=%h wren=1",
                         k, log_addr[k], log_data[k], log_wren[k], 32'h100 + k, 8'(wd >> (8 * k)));
            end
        end
    endtask

    task automatic test_half_read();
        rsp_delay = 8;
        drop_idx = -1;
        rsp_q.delete();
        rsp_q.push_back(8'h34);
        rsp_q.push_back(8'h12);
        run_access(1'b0, 2'b01, 23'h7FFFFF, 32'hFFFF_FFFF);
        checks++;
        if (log_addr.size() !== 2 || log_addr[0] !== 23'h7FFFFF || log_addr[1] !== 23'h000000) begin
            errors++;
            $display("FAIL half_read_wrap_addrs: got %0d reqs first=%h second=%h required 2 reqs 7fffff,000000",
                     log_addr.size(), log_addr.size() > 0 ? log_addr[0] : 23'h0, log_addr.size() > 1 ? log_addr[1] : 23'h0);
        end
        checks++;
        if (obs_rdata !== 32'h0000_1234 || obs_err !== 1'b0) begin
            errors++;
            $display("FAIL half_read_data: got rdata=%h err=%b required 00001234 err=0", obs_rdata, obs_err);
        end
        checks++;
        if (obs_lat !== 20) begin errors++; $display("FAIL half_read_latency: got %0d required 20", obs_lat); end
    endtask

    task automatic test_byte_read();
        rsp_delay = 8;
        drop_idx = -1;
        rsp_q.delete();
        rsp_q.push_back(8'hA5);
        run_access(1'b0, 2'b00, 23'h000010, 32'h0);
        checks++;
        if (log_addr.size() !== 1 || obs_ndone !== 1) begin
            errors++;
            $display("FAIL byte_read_counts: got reqs=%0d dones=%0d required 1 and 1", log_addr.size(), obs_ndone);
        end
        checks++;
        if (obs_rdata !== 32'h0000_00A5) begin errors++; $display("FAIL byte_read_data: got %h required 000000a5", obs_rdata); end
        checks++;
        if (o_rdata !== 32'h0000_00A5) begin errors++; $display("FAIL byte_read_hold: got %h required 000000a5", o_rdata); end
    endtask

    task automatic test_back_to_back();
        int d0;
        bit seen;
        rsp_delay = 3;
        drop_idx = -1;
        rsp_q.delete();
        rsp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h77};
        log_addr.delete();
        log_data.delete();
        log_wren.delete();
        @(negedge i_clk);
        d0 = done_cnt;
        i_request = 1'b1;
        i_wren = 1'b0;
        i_size = 2'b10;
        i_address = 23'h000200;
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge i_clk);
            if (o_done) seen = 1'b1;
        end
        checks++;
        if (!seen || o_rdata !== 32'h4433_2211) begin
            errors++;
            $display("FAIL b2b_first_done: seen=%b rdata=%h required 1 and 44332211", seen, o_rdata);
        end
        i_size = 2'b00;
        i_address = 23'h000300;
        @(negedge i_clk);
        checks++;
        if (o_busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_after_finish: busy=%b required 0", o_busy); end
        @(negedge i_clk);
        i_request = 1'b0;
        checks++;
        if (o_busy !== 1'b1) begin errors++; $display("FAIL b2b_second_accept: busy=%b required 1", o_busy); end
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge i_clk);
            if (o_done) seen = 1'b1;
        end
        checks++;
        if (!seen || o_rdata !== 32'h0000_0077) begin
            errors++;
            $display("FAIL b2b_second_done: seen=%b rdata=%h required 1 and 00000077", seen, o_rdata);
        end
        repeat (4) @(negedge i_clk);
        #1;
        checks++;
        if (log_addr.size() !== 5 || done_cnt - d0 !== 2) begin
            errors++;
            $display("FAIL b2b_counts: reqs=%0d dones=%0d required 5 and 2", log_addr.size(), done_cnt - d0);
        end
        for (int k = 0; k < 5 && k < log_addr.size(); k++) begin
            checks++;
            if (log_addr[k] !== ((k < 4) ? ADDR_W'(32'h200 + k) : 23'h000300)) begin
                errors++;
                $display("FAIL b2b_addr%0d: got %h required %h", k, log_addr[k], (k < 4) ? 32'h200 + k : 32'h300);
            end
        end
    endtask

    task automatic test_timeout();
        rsp_delay = 8;
        drop_idx = 1;
        rsp_q.delete();
        rsp_q = '{8'h5A, 8'h66, 8'h77, 8'h88};
        run_access(1'b0, 2'b10, 23'h001000, 32'h0);
        checks++;
        if (obs_err !== 1'b1 || obs_ndone !== 1) begin
            errors++;
            $display("FAIL timeout_error: err=%b dones=%0d required 1 and 1", obs_err, obs_ndone);
        end
        checks++;
        if (obs_lat !== 2 + 9 + TIMEOUT) begin errors++; $display("FAIL timeout_latency: got %0d required %0d", obs_lat, 2 + 9 + TIMEOUT); end
        checks++;
        if (obs_rdata !== 32'h0000_005A) begin errors++; $display("FAIL timeout_partial_data: got %h required 0000005a", obs_rdata); end
        checks++;
        if (log_addr.size() !== 2) begin errors++; $display("FAIL timeout_req_count: got %0d required 2", log_addr.size()); end
        drop_idx = -1;
    endtask

    task automatic test_illegal();
        rsp_delay = 4;
        drop_idx = -1;
        rsp_q.delete();
        run_access(1'b0, 2'b11, 23'h000020, 32'h0);
        checks++;
        if (obs_lat !== 2 || obs_err !== 1'b1) begin
            errors++;
            $display("FAIL illegal_size: lat=%0d err=%b required 2 and 1", obs_lat, obs_err);
        end
        checks++;
        if (log_addr.size() !== 0 || obs_ndone !== 1) begin
            errors++;
            $display("FAIL illegal_traffic: reqs=%0d dones=%0d required 0 and 1", log_addr.size(), obs_ndone);
        end
    endtask

    task automatic test_random();
        logic [7:0]        rb[4];
        logic              wren;
        logic [1:0]        size;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wd;
        logic [31:0]       exp_rd;
        int n, d, drop, answered, exp_req, exp_lat;
        logic exp_err;
        for (int it = 0; it < 24; it++) begin
            wren = 1'($urandom_range(0, 1));
            size = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            addr = ($urandom_range(0, 3) == 0) ? ADDR_W'(32'h7FFFFC + $urandom_range(0, 3)) : ADDR_W'($urandom);
            wd   = $urandom;
            d    = int'($urandom_range(1, 12));
            for (int k = 0; k < 4; k++) rb[k] = 8'($urandom);
            n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : (size == 2'b10) ? 4 : 0;
            drop = -1;
            if (n > 0 && $urandom_range(0, 3) == 0) drop = int'($urandom_range(0, n - 1));
            answered = (drop < 0) ? n : drop;
            exp_req  = (n == 0) ? 0 : (drop < 0) ? n : drop + 1;
            exp_err  = (n == 0) || (drop >= 0);
            exp_lat  = (n == 0) ? 2 : 2 + answered * (1 + d) + ((drop >= 0) ? TIMEOUT : 0);
            exp_rd   = '0;
            if (!wren) for (int k = 0; k < answered; k++) exp_rd = exp_rd | (32'(rb[k]) << (8 * k));
            rsp_delay = d;
            drop_idx  = drop;
            rsp_q.delete();
            for (int k = 0; k < 4; k++) rsp_q.push_back(rb[k]);
            run_access(wren, size, addr, wd);
            checks++;
            if (obs_lat !== exp_lat || obs_err !== exp_err || obs_ndone !== 1) begin
                errors++;
                $display("FAIL rand%0d_completion: lat=%0d err=%b dones=%0d required lat=%0d err=%b dones=1",
                         it, obs_lat, obs_err, obs_ndone, exp_lat, exp_err);
            end
            checks++;
            if (obs_rdata !== exp_rd) begin errors++; $display("FAIL rand%0d_rdata: got %h required %h", it, obs_rdata, exp_rd); end
            checks++;
            if (log_addr.size() !== exp_req) begin
                errors++;
                $display("FAIL rand%0d_req_count: got %0d required %0d", it, log_addr.size(), exp_req);
            end
            for (int k = 0; k < exp_req && k < log_addr.size(); k++) begin
                checks++;
                if (log_addr[k] !== ADDR_W'((int'(addr) + k) % (1 << ADDR_W)) || log_wren[k] !== wren ||
                    (wren && log_data[k] !== 8'((wd >> (8 * k)) & 32'hFF))) begin
                    errors++;
                    $display("FAIL rand%0d_byte%0d: addr=%h data=%h wren=%b required addr=%h data=%h wren=%b",
                             it, k, log_addr[k], log_data[k], log_wren[k],
                             ADDR_W'((int'(addr) + k) % (1 << ADDR_W)), 8'(wd >> (8 * k)), wren);
                end
            end
        end
        drop_idx = -1;
    endtask

    task automatic test_reset_mid();
        int d0;
        rsp_delay = 10;
        drop_idx = -1;
        rsp_q.delete();
        rsp_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        log_addr.delete();
        log_data.delete();
        log_wren.delete();
        @(negedge i_clk);
        d0 = done_cnt;
        i_request = 1'b1;
        i_wren = 1'b0;
        i_size = 2'b10;
        i_address = 23'h000040;
        @(negedge i_clk);
        i_request = 1'b0;
        repeat (4) @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        checks++;
        if ({o_rdata, o_done, o_error, o_busy, o_sd_request, o_sd_wren, o_sd_address, o_sd_data} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: rdata=%h done=%b err=%b busy=%b sreq=%b swren=%b saddr=%h sdata=%h, required all zero",
                     o_rdata, o_done, o_error, o_busy, o_sd_request, o_sd_wren, o_sd_address, o_sd_data);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (20) @(negedge i_clk);
        #1;
        checks++;
        if (done_cnt !== d0 || log_addr.size() !== 1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_quiet: dones=%0d reqs=%0d busy=%b required 0, 1, 0", done_cnt - d0, log_addr.size(), o_busy);
        end
    endtask

    initial begin
        test_reset();
        test_word_write();
        test_half_read();
        test_byte_read();
        test_back_to_back();
        test_timeout();
        test_illegal();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
